// File: rtl/div_arbiter_if.sv
// Requester-side bundle for div_arbiter.
// It carries the operand handshake, the per-requester flush and the result return.
// The arbiter uses the slave modport; requesters (or a testbench) use master.
interface div_arbiter_if #(
    parameter int DW   = 32,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ*DW-1:0] req_op1_i;
    logic [NREQ*DW-1:0] req_op2_i;
    logic [NREQ-1:0]    req_signed_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ-1:0]    cancel_i;
    logic [NREQ-1:0]    resp_valid_o;
    logic [2*DW-1:0]    resp_result_o;

    modport master (
        output req_valid_i, req_op1_i, req_op2_i, req_signed_i, cancel_i,
        input  req_ready_o, resp_valid_o, resp_result_o
    );

    modport slave (
        input  req_valid_i, req_op1_i, req_op2_i, req_signed_i, cancel_i,
        output req_ready_o, resp_valid_o, resp_result_o
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider between NREQ requesters.
// Requester 0 is the EX stage.
// Grants are round-robin, starting after the last owner. The owner can flush an
// in-flight divide, which issues a one-cycle annul to the divider.
// The result {remainder, quotient} goes back only to the owner.
// Optional feature macro: DIV_ZERO_BYPASS_EN. When it is defined, a zero divisor
// skips the divider and returns 0 one cycle after acceptance.
module div_arbiter #(
    parameter int DW   = 32,
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    div_arbiter_if.slave    req,
    output logic            busy_o,
    output logic [DW-1:0]   div_opdata1_o,
    output logic [DW-1:0]   div_opdata2_o,
    output logic            div_start_o,
    output logic            signed_div_o,
    output logic            div_annul_o,
    input  logic [2*DW-1:0] div_result_i,
    input  logic            div_ready_i
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESP    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [DW-1:0]   op1_q, op1_d;
    logic [DW-1:0]   op2_q, op2_d;
    logic            signed_q, signed_d;
    logic [2*DW-1:0] result_q, result_d;

    logic [NREQ-1:0] eligible;
    logic            grant_valid;
    logic [OW-1:0]   grant_idx;
    logic [OW-1:0]   cand;
    logic [DW-1:0]   sel_op1;
    logic [DW-1:0]   sel_op2;
    logic            sel_signed;
    logic            owner_cancel;

    // Round-robin pick: first eligible requester strictly after last_owner, with wrap-around.
    always_comb begin
        eligible    = req.req_valid_i & ~req.cancel_i;
        grant_valid = 1'b0;
        grant_idx   = last_owner_q;
        cand        = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = OW'((int'(last_owner_q) + i) % NREQ);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        sel_op1    = '0;
        sel_op2    = '0;
        sel_signed = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == OW'(k)) begin
                sel_op1    = req.req_op1_i[k*DW +: DW];
                sel_op2    = req.req_op2_i[k*DW +: DW];
                sel_signed = req.req_signed_i[k];
            end
        end
        owner_cancel = req.cancel_i[owner_q];
    end

    // Next state: grant in IDLE, wait on the divider or a flush in BUSY, then RESP and RELEASE.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        signed_d     = signed_q;
        result_d     = result_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    owner_d      = grant_idx;
                    last_owner_d = grant_idx;
                    op1_d        = sel_op1;
                    op2_d        = sel_op2;
                    signed_d     = sel_signed;
`ifdef DIV_ZERO_BYPASS_EN
                    if (sel_op2 == '0) begin
                        result_d = '0;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_BUSY;
                    end
`else
                    state_d      = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                if (owner_cancel) begin
                    state_d = S_RELEASE;
                end else if (div_ready_i) begin
                    result_d = div_result_i;
                    state_d  = S_RESP;
                end
            end
            S_RESP:    state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State and latched transaction registers. Reset points last_owner at NREQ-1, so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NREQ - 1);
            op1_q        <= '0;
            op2_q        <= '0;
            signed_q     <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            signed_q     <= signed_d;
            result_q     <= result_d;
        end
    end

    // Outputs are decoded from the registered state, so reset clears them immediately.
    // ready is additionally gated by rst.
    always_comb begin
        busy_o            = (state_q != S_IDLE);
        req.req_ready_o   = '0;
        req.resp_valid_o  = '0;
        req.resp_result_o = '0;
        div_opdata1_o     = '0;
        div_opdata2_o     = '0;
        signed_div_o      = 1'b0;
        div_start_o       = 1'b0;
        div_annul_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_valid && rst) begin
                    req.req_ready_o = ONE << grant_idx;
                end
            end
            S_BUSY: begin
                div_opdata1_o = op1_q;
                div_opdata2_o = op2_q;
                signed_div_o  = signed_q;
                if (owner_cancel) begin
                    div_annul_o = 1'b1;
                end else begin
                    div_start_o = 1'b1;
                end
            end
            S_RESP: begin
                req.resp_valid_o  = ONE << owner_q;
                req.resp_result_o = result_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed testbench for div_arbiter with two requesters.
// The bench plays the role of the divider by driving div_ready_i and div_result_i itself.
module tb_div_arbiter;

    localparam int DW   = 32;
    localparam int NREQ = 2;

    logic            clk;
    logic            rst;
    logic            busy_o;
    logic [DW-1:0]   div_opdata1_o;
    logic [DW-1:0]   div_opdata2_o;
    logic            div_start_o;
    logic            signed_div_o;
    logic            div_annul_o;
    logic [2*DW-1:0] div_result_i;
    logic            div_ready_i;

    int n_compared;
    int n_mismatched;

    div_arbiter_if #(.DW(DW), .NREQ(NREQ)) bus ();

    div_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (bus),
        .busy_o        (busy_o),
        .div_opdata1_o (div_opdata1_o),
        .div_opdata2_o (div_opdata2_o),
        .div_start_o   (div_start_o),
        .signed_div_o  (signed_div_o),
        .div_annul_o   (div_annul_o),
        .div_result_i  (div_result_i),
        .div_ready_i   (div_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task step();
        @(posedge clk);
        #1;
    endtask

    task clear_inputs();
        bus.req_valid_i  = '0;
        bus.req_op1_i    = '0;
        bus.req_op2_i    = '0;
        bus.req_signed_i = '0;
        bus.cancel_i     = '0;
        div_result_i     = '0;
        div_ready_i      = 1'b0;
    endtask

    task test_reset();
        rst = 1'b0;
        bus.req_valid_i          = 2'b01;
        bus.req_op1_i[0 +: DW]   = 32'd1;
        bus.req_op2_i[0 +: DW]   = 32'd1;
        #12;
        n_compared++;
        if (bus.req_ready_o !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %b expected 00", bus.req_ready_o); end
        n_compared++;
        if (busy_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        n_compared++;
        if ({div_start_o, div_annul_o, signed_div_o} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_div_ctrl: got %b expected 000", {div_start_o, div_annul_o, signed_div_o}); end
        n_compared++;
        if (bus.resp_valid_o !== 2'b00 || bus.resp_result_o !== 64'd0) begin n_mismatched++; $display("[TB] FAIL reset_resp: got %b/%h expected 00/0", bus.resp_valid_o, bus.resp_result_o); end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task test_unsigned();
        int start_high;
        start_high = 0;
        bus.req_valid_i        = 2'b01;
        bus.req_op1_i[0 +: DW] = 32'd100;
        bus.req_op2_i[0 +: DW] = 32'd7;
        bus.req_signed_i       = 2'b00;
        #1;
        n_compared++;
        if (bus.req_ready_o !== 2'b01) begin n_mismatched++; $display("[TB] FAIL unsigned_ready: got %b expected 01", bus.req_ready_o); end
        step();
        bus.req_valid_i = 2'b00;
        #1;
        n_compared++;
        if (div_opdata1_o !== 32'd100 || div_opdata2_o !== 32'd7 || signed_div_o !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL unsigned_operands: got %h/%h/%b expected 00000064/00000007/0", div_opdata1_o, div_opdata2_o, signed_div_o);
        end
        for (int i = 0; i < 34; i++) begin
            if (i == 33) begin
                div_ready_i  = 1'b1;
                div_result_i = 64'h00000002_0000000E;
            end
            #1;
            if (div_start_o === 1'b1 && busy_o === 1'b1) start_high++;
            step();
        end
        n_compared++;
        if (start_high !== 34) begin n_mismatched++; $display("[TB] FAIL unsigned_start_cycles: got %0d expected 34", start_high); end
        div_ready_i  = 1'b0;
        div_result_i = '0;
        #1;
        n_compared++;
        if (bus.resp_valid_o !== 2'b01) begin n_mismatched++; $display("[TB] FAIL unsigned_resp_valid: got %b expected 01", bus.resp_valid_o); end
        n_compared++;
        if (bus.resp_result_o !== 64'h00000002_0000000E) begin n_mismatched++; $display("[TB] FAIL unsigned_result: got %h expected 000000020000000e", bus.resp_result_o); end
        n_compared++;
        if (div_start_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL unsigned_resp_start: got %b expected 0", div_start_o); end
        step();
        n_compared++;
        if (busy_o !== 1'b1 || bus.resp_valid_o !== 2'b00 || div_start_o !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL unsigned_release: got busy=%b resp=%b start=%b expected 1/00/0", busy_o, bus.resp_valid_o, div_start_o);
        end
        step();
        n_compared++;
        if (busy_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL unsigned_idle: got %b expected 0", busy_o); end
    endtask

    task test_signed();
        bus.req_valid_i        = 2'b01;
        bus.req_op1_i[0 +: DW] = 32'hFFFFFFF9;
        bus.req_op2_i[0 +: DW] = 32'h00000002;
        bus.req_signed_i       = 2'b01;
        #1;
        n_compared++;
        if (bus.req_ready_o !== 2'b01) begin n_mismatched++; $display("[TB] FAIL signed_ready: got %b expected 01", bus.req_ready_o); end
        step();
        bus.req_valid_i = 2'b00;
        #1;
        n_compared++;
        if (signed_div_o !== 1'b1 || div_opdata1_o !== 32'hFFFFFFF9) begin
            n_mismatched++; $display("[TB] FAIL signed_operands: got %b/%h expected 1/fffffff9", signed_div_o, div_opdata1_o);
        end
        step();
        step();
        div_ready_i  = 1'b1;
        div_result_i = 64'hFFFFFFFF_FFFFFFFD;
        step();
        div_ready_i  = 1'b0;
        #1;
        n_compared++;
        if (bus.resp_valid_o !== 2'b01 || bus.resp_result_o !== 64'hFFFFFFFF_FFFFFFFD) begin
            n_mismatched++; $display("[TB] FAIL signed_result: got %b/%h expected 01/fffffffffffffffd", bus.resp_valid_o, bus.resp_result_o);
        end
        step();
        step();
        bus.req_signed_i = 2'b00;
    endtask

    task test_round_robin();
        int              exp_owner;
        logic [NREQ-1:0] exp_oh;
        logic [DW-1:0]   exp_op1;
        logic [2*DW-1:0] rr_res;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        bus.req_op1_i[0 +: DW]  = 32'd1000;
        bus.req_op2_i[0 +: DW]  = 32'd10;
        bus.req_op1_i[DW +: DW] = 32'd2000;
        bus.req_op2_i[DW +: DW] = 32'd20;
        bus.req_valid_i = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_owner = g % 2;
            exp_oh    = 2'b01 << exp_owner;
            exp_op1   = (exp_owner == 1) ? 32'd2000 : 32'd1000;
            rr_res    = {32'(g + 16), 32'(exp_owner + 256)};
            #1;
            n_compared++;
            if (bus.req_ready_o !== exp_oh) begin n_mismatched++; $display("[TB] FAIL rr_ready_%0d: got %b expected %b", g, bus.req_ready_o, exp_oh); end
            step();
            n_compared++;
            if (div_opdata1_o !== exp_op1) begin n_mismatched++; $display("[TB] FAIL rr_op1_%0d: got %0d expected %0d", g, div_opdata1_o, exp_op1); end
            div_ready_i  = 1'b1;
            div_result_i = rr_res;
            step();
            div_ready_i  = 1'b0;
            #1;
            n_compared++;
            if (bus.resp_valid_o !== exp_oh || bus.resp_result_o !== rr_res) begin
                n_mismatched++; $display("[TB] FAIL rr_resp_%0d: got %b/%h expected %b/%h", g, bus.resp_valid_o, bus.resp_result_o, exp_oh, rr_res);
            end
            step();
            n_compared++;
            if (bus.req_ready_o !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rr_release_ready_%0d: got %b expected 00", g, bus.req_ready_o); end
            step();
        end
        bus.req_valid_i = 2'b00;
    endtask

    task test_cancel();
        int bad;
        bad = 0;
        bus.req_valid_i         = 2'b10;
        bus.req_op1_i[DW +: DW] = 32'd50;
        bus.req_op2_i[DW +: DW] = 32'd5;
        #1;
        n_compared++;
        if (bus.req_ready_o !== 2'b10) begin n_mismatched++; $display("[TB] FAIL cancel_grant1: got %b expected 10", bus.req_ready_o); end
        step();
        bus.req_valid_i = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            bus.cancel_i = (i == 2) ? 2'b01 : 2'b00;
            #1;
            if (div_start_o !== 1'b1 || div_annul_o !== 1'b0) bad++;
            step();
        end
        n_compared++;
        if (bad !== 0) begin n_mismatched++; $display("[TB] FAIL cancel_nonowner: got %0d bad cycles expected 0", bad); end
        bus.cancel_i = 2'b10;
        #1;
        n_compared++;
        if (div_annul_o !== 1'b1 || div_start_o !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL cancel_annul: got annul=%b start=%b expected 1/0", div_annul_o, div_start_o);
        end
        step();
        bus.cancel_i = 2'b00;
        #1;
        n_compared++;
        if (bus.resp_valid_o !== 2'b00 || div_annul_o !== 1'b0 || busy_o !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL cancel_release: got resp=%b annul=%b busy=%b expected 00/0/1", bus.resp_valid_o, div_annul_o, busy_o);
        end
        bus.req_valid_i        = 2'b11;
        bus.req_op1_i[0 +: DW] = 32'd77;
        bus.req_op2_i[0 +: DW] = 32'd11;
        step();
        n_compared++;
        if (busy_o !== 1'b0 || bus.req_ready_o !== 2'b01) begin
            n_mismatched++; $display("[TB] FAIL cancel_next_grant: got busy=%b ready=%b expected 0/01", busy_o, bus.req_ready_o);
        end
        step();
        bus.req_valid_i = 2'b00;
        bus.cancel_i    = 2'b01;
        div_ready_i     = 1'b1;
        div_result_i    = 64'h12345678_9ABCDEF0;
        #1;
        n_compared++;
        if (div_annul_o !== 1'b1 || div_start_o !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL cancel_vs_ready_annul: got annul=%b start=%b expected 1/0", div_annul_o, div_start_o);
        end
        step();
        bus.cancel_i = 2'b00;
        div_ready_i  = 1'b0;
        #1;
        n_compared++;
        if (bus.resp_valid_o !== 2'b00 || busy_o !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL cancel_vs_ready_noresp: got resp=%b busy=%b expected 00/1", bus.resp_valid_o, busy_o);
        end
        step();
    endtask

    task test_ready_outside_busy();
        div_ready_i  = 1'b1;
        div_result_i = 64'hDEADBEEF_CAFEF00D;
        step();
        step();
        n_compared++;
        if (busy_o !== 1'b0 || bus.resp_valid_o !== 2'b00) begin
            n_mismatched++; $display("[TB] FAIL idle_ready_ignored: got busy=%b resp=%b expected 0/00", busy_o, bus.resp_valid_o);
        end
        div_ready_i  = 1'b0;
        div_result_i = '0;
    endtask

    task test_reset_mid_busy();
        int resp_seen;
        resp_seen = 0;
        bus.req_valid_i        = 2'b01;
        bus.req_op1_i[0 +: DW] = 32'd9;
        bus.req_op2_i[0 +: DW] = 32'd3;
        #1;
        step();
        bus.req_valid_i = 2'b00;
        #1;
        n_compared++;
        if (div_start_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_pre_start: got %b expected 1", div_start_o); end
        #1;
        rst = 1'b0;
        #1;
        n_compared++;
        if (div_start_o !== 1'b0 || div_annul_o !== 1'b0 || busy_o !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL midreset_async: got start=%b annul=%b busy=%b expected 0/0/0", div_start_o, div_annul_o, busy_o);
        end
        div_ready_i  = 1'b1;
        div_result_i = 64'h00000003_00000000;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.resp_valid_o !== 2'b00) resp_seen++;
        end
        n_compared++;
        if (resp_seen !== 0) begin n_mismatched++; $display("[TB] FAIL midreset_noresp: got %0d pulses expected 0", resp_seen); end
        div_ready_i  = 1'b0;
        div_result_i = '0;
    endtask

    task test_div_zero();
        bus.req_valid_i        = 2'b01;
        bus.req_op1_i[0 +: DW] = 32'd5;
        bus.req_op2_i[0 +: DW] = 32'd0;
        #1;
        n_compared++;
        if (bus.req_ready_o !== 2'b01) begin n_mismatched++; $display("[TB] FAIL zero_ready: got %b expected 01", bus.req_ready_o); end
        step();
        bus.req_valid_i = 2'b00;
        #1;
`ifdef DIV_ZERO_BYPASS_EN
        n_compared++;
        if (bus.resp_valid_o !== 2'b01 || bus.resp_result_o !== 64'd0 || div_start_o !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL zero_bypass: got resp=%b res=%h start=%b expected 01/0/0", bus.resp_valid_o, bus.resp_result_o, div_start_o);
        end
        step();
        n_compared++;
        if (div_start_o !== 1'b0 || div_annul_o !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL zero_bypass_release: got start=%b annul=%b expected 0/0", div_start_o, div_annul_o);
        end
        step();
`else
        n_compared++;
        if (div_start_o !== 1'b1 || div_opdata2_o !== 32'd0 || div_opdata1_o !== 32'd5) begin
            n_mismatched++; $display("[TB] FAIL zero_forward: got start=%b op1=%h op2=%h expected 1/00000005/00000000", div_start_o, div_opdata1_o, div_opdata2_o);
        end
        div_ready_i  = 1'b1;
        div_result_i = 64'h00000005_FFFFFFFF;
        step();
        div_ready_i  = 1'b0;
        #1;
        n_compared++;
        if (bus.resp_valid_o !== 2'b01 || bus.resp_result_o !== 64'h00000005_FFFFFFFF) begin
            n_mismatched++; $display("[TB] FAIL zero_result: got %b/%h expected 01/00000005ffffffff", bus.resp_valid_o, bus.resp_result_o);
        end
        step();
        step();
`endif
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_round_robin();
        test_cancel();
        test_ready_outside_busy();
        test_reset_mid_busy();
        test_div_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
